matrix_bcm: RTL

- Next-generation HUB75-style LED matrix scan driver with binary-coded modulation (BCM) of a parametrised colour depth.
- Reads pixels from a synchronous frame buffer and drives `channels` parallel RGB lanes, serial clock, latch, output-enable and row select.
- Adds global brightness, anti-ghosting blanking, run/stop control and a frame-done strobe for buffer swapping.
- Sits between the frame-buffer RAM (UART-loaded) and the panel pins.

---
 rtl/matrix_pkg.sv | 30 +++
 rtl/matrix_bcm_if.sv | 34 +++
 rtl/matrix_shifter.sv | 93 +++++++++
 rtl/matrix_bcm.sv | 127 ++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the HUB75 BCM scan driver.
// No logic, so no latency.
// No flow control; widths only.
package matrix_pkg;

  // Scan FSM states, in scan order
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_e;

  // Bits per lane in the frame-buffer word: {R,G,B}, depth bits each
  function automatic int lane_bits(input int depth);
    return 3 * depth;
  endfunction

  // Column index width; never zero so a one-column panel still has a field
  function automatic int col_w(input int length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

  // Bitplane index width
  function automatic int plane_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matrix_bcm_if.sv
// Frame-buffer read port plus panel pins of the BCM scan driver.
// Wires only, no latency.
// No backpressure: data returns a fixed one clk after addr.
interface matrix_bcm_if
  import matrix_pkg::*;
#(
  parameter int length   = 32,
  parameter int scan_bit = 4,
  parameter int channels = 2,
  parameter int depth    = 8
);

  logic                                  enable;
  logic [7:0]                            bright;
  logic [scan_bit+col_w(length)-1:0]     addr;
  logic [channels*lane_bits(depth)-1:0]  data;
  logic [channels*3-1:0]                 rgb;
  logic                                  sclk;
  logic                                  latch;
  logic                                  oe_b;
  logic [scan_bit-1:0]                   select;
  logic                                  frame_done;

  modport master (
    input  enable, bright, data,
    output addr, rgb, sclk, latch, oe_b, select, frame_done
  );

  modport slave (
    output enable, bright, data,
    input  addr, rgb, sclk, latch, oe_b, select, frame_done
  );

endinterface

// File: rtl/matrix_shifter.sv
// Shifts one row of one bitplane into the panel: addr, rgb and sclk per column.
// length*2*divider cycles from start to done; rgb registered one clk after data.
// No backpressure; start is ignored while a row is in flight.
module matrix_shifter
  import matrix_pkg::*;
#(
  parameter int divider  = 3,
  parameter int length   = 32,
  parameter int scan_bit = 4,
  parameter int channels = 2,
  parameter int depth    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_b,
  input  logic                                 start,
  input  logic [plane_w(depth)-1:0]            plane,
  input  logic [scan_bit-1:0]                  row,
  output logic [scan_bit+col_w(length)-1:0]    addr,
  input  logic [channels*lane_bits(depth)-1:0] data,
  output logic [channels*3-1:0]                rgb,
  output logic                                 sclk,
  output logic                                 done
);

  localparam int CW = col_w(length);
  localparam int SW = $clog2(2 * divider);
  localparam int LB = lane_bits(depth);

  localparam logic [SW-1:0] SLOT_LAST = SW'(2 * divider - 1);
  localparam logic [SW-1:0] SLOT_HI   = SW'(divider);
  localparam logic [SW-1:0] SLOT_CAP  = SW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(length - 1);

  logic                  active;
  logic [SW-1:0]         slot;
  logic [CW-1:0]         col;
  logic [channels*3-1:0] rgb_nxt;
  logic [depth-1:0]      comp_r, comp_g, comp_b;

  // Address is presented in slot 0; the RAM answers during slot 1
  assign addr = {row, col};
  assign sclk = active && (slot >= SLOT_HI);
  assign done = active && (slot == SLOT_LAST) && (col == COL_LAST);

  // Column slot timing: 2*divider cycles per column, stop after the last one
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      active <= 1'b0;
      slot   <= '0;
      col    <= '0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        slot   <= '0;
        col    <= '0;
      end
    end else if (slot == SLOT_LAST) begin
      slot <= '0;
      if (col == COL_LAST) begin
        active <= 1'b0;
        col    <= '0;
      end else begin
        col <= col + CW'(1);
      end
    end else begin
      slot <= slot + SW'(1);
    end
  end

  // Pick the current bitplane out of every component of every lane
  always_comb begin
    rgb_nxt = '0;
    comp_r  = '0;
    comp_g  = '0;
    comp_b  = '0;
    for (int c = 0; c < channels; c++) begin
      comp_r = data[c*LB + 2*depth +: depth];
      comp_g = data[c*LB + depth +: depth];
      comp_b = data[c*LB +: depth];
      rgb_nxt[c*3 +: 3] = {comp_r[plane], comp_g[plane], comp_b[plane]};
    end
  end

  // Capture pixel bits at the end of slot 1 so they are settled before sclk rises
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rgb <= '0;
    end else if (active && (slot == SLOT_CAP)) begin
      rgb <= rgb_nxt;
    end
  end

endmodule

// File: rtl/matrix_bcm.sv
// HUB75 scan driver with binary-coded modulation, brightness and blanking.
// Per plane: length*2*divider shift + blank + divider latch + (bright+1)<<plane display.
// No backpressure; enable low stops the scan only at the end of a display phase.
module matrix_bcm
  import matrix_pkg::*;
#(
  parameter int divider  = 3,
  parameter int length   = 32,
  parameter int scan_bit = 4,
  parameter int channels = 2,
  parameter int depth    = 8,
  parameter int blank    = 4
) (
  input  logic          clk,
  input  logic          reset_b,
  matrix_bcm_if.master  bus
);

  localparam int PW   = plane_w(depth);
  // Holds (255+1) << (depth-1) without overflow
  localparam int CNTW = 8 + depth;

  state_e              state;
  logic [CNTW-1:0]     cnt;
  logic [CNTW-1:0]     disp_load;
  logic [PW-1:0]       plane;
  logic [scan_bit-1:0] row;
  logic [scan_bit-1:0] select_q;
  logic                frame_done_q;
  logic                start;
  logic                sh_done;
  logic                cnt_zero;
  logic                disp_end;
  logic                last_plane;
  logic                last_row;

  assign cnt_zero   = (cnt == '0);
  assign disp_end   = (state == DISPLAY) && cnt_zero;
  assign last_plane = (plane == PW'(depth - 1));
  assign last_row   = &row;
  // The shifter starts in the same edge the FSM enters SHIFT
  assign start      = bus.enable && ((state == IDLE) || disp_end);
  // Display length minus one, so the counter ends on zero
  assign disp_load  = ((CNTW'(bus.bright) + CNTW'(1)) << plane) - CNTW'(1);

  assign bus.latch      = (state == LATCH);
  assign bus.oe_b       = (state != DISPLAY);
  assign bus.select     = select_q;
  assign bus.frame_done = frame_done_q;

  matrix_shifter #(
    .divider  (divider),
    .length   (length),
    .scan_bit (scan_bit),
    .channels (channels),
    .depth    (depth)
  ) u_shifter (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (start),
    .plane   (plane),
    .row     (row),
    .addr    (bus.addr),
    .data    (bus.data),
    .rgb     (bus.rgb),
    .sclk    (bus.sclk),
    .done    (sh_done)
  );

  // Scan FSM: phase timing, row/plane stepping, select update and frame strobe
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      cnt          <= '0;
      plane        <= '0;
      row          <= '0;
      select_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= disp_end && last_plane && last_row;
      case (state)
        IDLE: begin
          if (bus.enable) state <= SHIFT;
        end
        SHIFT: begin
          if (sh_done) begin
            state <= BLANK;
            cnt   <= CNTW'(blank - 1);
          end
        end
        BLANK: begin
          if (cnt_zero) begin
            state    <= LATCH;
            cnt      <= CNTW'(divider - 1);
            // Row changes while the LEDs are dark to avoid ghosting
            select_q <= row;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        LATCH: begin
          if (cnt_zero) begin
            state <= DISPLAY;
            cnt   <= disp_load;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        DISPLAY: begin
          if (cnt_zero) begin
            state <= bus.enable ? SHIFT : IDLE;
            if (last_plane) begin
              plane <= '0;
              row   <= row + scan_bit'(1);
            end else begin
              plane <= plane + PW'(1);
            end
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
